// File: rtl/l1d_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-through L1 data cache.
package l1d_pkg;
  localparam int LINES   = 128;
  localparam int ADDR_W  = 23;
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_RD,
    MEM_WR,
    DONE
  } state_t;
endpackage

// File: rtl/l1d_tag_store.sv
// Valid/tag/data line storage: one combinational read port, one write port.
// Only the valid bits are cleared by reset.
module l1d_tag_store #(
  parameter int LINES   = 128,
  parameter int INDEX_W = 7,
  parameter int TAG_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic               clk100,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  always_ff @(posedge clk100) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk100) begin
    if (wr_en && !reset) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = words[rd_index];
endmodule

// File: rtl/l1d_cache.sv
// Direct-mapped, one-word-line, write-through/write-allocate L1 data cache
// in front of the SDRAM controller word port.
module l1d_cache
  import l1d_pkg::state_t, l1d_pkg::IDLE, l1d_pkg::LOOKUP,
         l1d_pkg::MEM_RD, l1d_pkg::MEM_WR, l1d_pkg::DONE;
#(
  parameter int LINES  = l1d_pkg::LINES,
  parameter int ADDR_W = l1d_pkg::ADDR_W
) (
  input  logic              clk100,
  input  logic              reset,
  input  logic [ADDR_W-1:0] bus_l1d_addr,
  input  logic              bus_l1d_start,
  input  logic [31:0]       bus_l1d_data,
  input  logic              bus_l1d_we,
  output logic [31:0]       bus_l1d_q,
  output logic              bus_l1d_done,
  output logic              bus_l1d_ready,
  output logic [ADDR_W-1:0] sdc_addr,
  output logic [31:0]       sdc_data,
  output logic              sdc_we,
  output logic              sdc_start,
  input  logic [31:0]       sdc_q,
  input  logic              sdc_done
);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  state_t state, state_next;

  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        data_q;
  logic               we_q;
  logic [31:0]        q_r;
  logic               start_pulse;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               wr_en;
  logic [31:0]        wr_data;

  assign req_index = addr_q[INDEX_W-1:0];
  assign req_tag   = addr_q[ADDR_W-1:INDEX_W];
  assign hit       = rd_valid && (rd_tag == req_tag);

  l1d_tag_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (32)
  ) u_store (
    .clk100   (clk100),
    .reset    (reset),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (req_index),
    .wr_tag   (req_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk100) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:           if (bus_l1d_start) state_next = LOOKUP;
      LOOKUP: begin
        if (we_q)     state_next = MEM_WR;
        else if (hit) state_next = DONE;
        else          state_next = MEM_RD;
      end
      MEM_RD, MEM_WR: if (sdc_done) state_next = DONE;
      DONE:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  // Outputs are gated by reset so the reset cycle itself shows an idle, non-ready port.
  always_comb begin
    bus_l1d_ready = (state == IDLE) && !reset;
    bus_l1d_done  = (state == DONE) && !reset;
    sdc_we        = (state == MEM_WR) && !reset;
    sdc_start     = start_pulse && !reset;
    wr_en         = ((state == MEM_RD) || (state == MEM_WR)) && sdc_done && !reset;
    wr_data       = (state == MEM_RD) ? sdc_q : data_q;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      q_r         <= '0;
      start_pulse <= 1'b0;
    end else begin
      start_pulse <= (state == LOOKUP) && (state_next != DONE);
      if (state == LOOKUP && hit && !we_q)
        q_r <= rd_data;
      else if (state == MEM_RD && sdc_done)
        q_r <= sdc_q;
    end
  end

  always_ff @(posedge clk100) begin
    if (state == IDLE && bus_l1d_start) begin
      addr_q <= bus_l1d_addr;
      data_q <= bus_l1d_data;
      we_q   <= bus_l1d_we;
    end
  end

  assign bus_l1d_q = q_r;
  assign sdc_addr  = addr_q;
  assign sdc_data  = data_q;
endmodule

// File: tb/tb_l1d_cache.sv
// Directed bench for l1d_cache: hand-driven SDRAM responses and immediate-assertion checks.
module tb_l1d_cache;
  logic        clk100 = 1'b0;
  logic        reset  = 1'b1;
  logic [22:0] bus_l1d_addr = '0;
  logic        bus_l1d_start = 1'b0;
  logic [31:0] bus_l1d_data = '0;
  logic        bus_l1d_we = 1'b0;
  logic [31:0] bus_l1d_q;
  logic        bus_l1d_done;
  logic        bus_l1d_ready;
  logic [22:0] sdc_addr;
  logic [31:0] sdc_data;
  logic        sdc_we;
  logic        sdc_start;
  logic [31:0] sdc_q = '0;
  logic        sdc_done = 1'b0;

  int checks = 0;
  int errors = 0;
  int n_sdc_start = 0;
  int n_done = 0;
  int s0, d0;

  l1d_cache #(.LINES(128), .ADDR_W(23)) dut (
    .clk100        (clk100),
    .reset         (reset),
    .bus_l1d_addr  (bus_l1d_addr),
    .bus_l1d_start (bus_l1d_start),
    .bus_l1d_data  (bus_l1d_data),
    .bus_l1d_we    (bus_l1d_we),
    .bus_l1d_q     (bus_l1d_q),
    .bus_l1d_done  (bus_l1d_done),
    .bus_l1d_ready (bus_l1d_ready),
    .sdc_addr      (sdc_addr),
    .sdc_data      (sdc_data),
    .sdc_we        (sdc_we),
    .sdc_start     (sdc_start),
    .sdc_q         (sdc_q),
    .sdc_done      (sdc_done)
  );

  always #5 clk100 = ~clk100;

  always @(posedge clk100) begin
    if (sdc_start)    n_sdc_start++;
    if (bus_l1d_done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic issue(input string tag, input logic [22:0] a, input logic [31:0] d, input logic w);
    chk({tag, "_ready"}, {31'b0, bus_l1d_ready}, 32'd1);
    bus_l1d_addr  = a;
    bus_l1d_data  = d;
    bus_l1d_we    = w;
    bus_l1d_start = 1'b1;
    tick();
    bus_l1d_start = 1'b0;
    bus_l1d_addr  = 23'h7FFFFF;
    bus_l1d_data  = 32'hA5A5A5A5;
  endtask

  task automatic serve(input string tag, input logic [22:0] ea, input logic [31:0] ed,
                       input logic ew, input logic [31:0] rq, input int lat);
    int k = 0;
    while (!sdc_start && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_sdc_start"}, {31'b0, sdc_start}, 32'd1);
    chk({tag, "_sdc_addr"}, {9'b0, sdc_addr}, {9'b0, ea});
    chk({tag, "_sdc_we"}, {31'b0, sdc_we}, {31'b0, ew});
    if (ew) chk({tag, "_sdc_data"}, sdc_data, ed);
    for (int i = 0; i < lat; i++) begin
      tick();
      if (i == 0) chk({tag, "_sdc_start_1cyc"}, {31'b0, sdc_start}, 32'd0);
    end
    chk({tag, "_sdc_addr_held"}, {9'b0, sdc_addr}, {9'b0, ea});
    sdc_q    = rq;
    sdc_done = 1'b1;
    tick();
    sdc_done = 1'b0;
    sdc_q    = 32'h0;
  endtask

  initial begin
    #1;
    chk("rst_ready", {31'b0, bus_l1d_ready}, 32'd0);
    chk("rst_done", {31'b0, bus_l1d_done}, 32'd0);
    chk("rst_sdc_start", {31'b0, sdc_start}, 32'd0);
    chk("rst_sdc_we", {31'b0, sdc_we}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, bus_l1d_ready}, 32'd1);
    chk("post_rst_q", bus_l1d_q, 32'h0);

    // cold read miss
    s0 = n_sdc_start; d0 = n_done;
    issue("rd_miss", 23'h000010, 32'h0, 1'b0);
    serve("rd_miss", 23'h000010, 32'h0, 1'b0, 32'hDEADBEEF, 5);
    chk("rd_miss_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("rd_miss_q", bus_l1d_q, 32'hDEADBEEF);
    tick();
    chk("rd_miss_done_1cyc", {31'b0, bus_l1d_done}, 32'd0);
    chk("rd_miss_ready", {31'b0, bus_l1d_ready}, 32'd1);
    chk("rd_miss_nstart", n_sdc_start - s0, 32'd1);
    chk("rd_miss_ndone", n_done - d0, 32'd1);

    // read hit: done two cycles after start
    s0 = n_sdc_start;
    issue("rd_hit", 23'h000010, 32'h0, 1'b0);
    chk("rd_hit_not_yet", {31'b0, bus_l1d_done}, 32'd0);
    tick();
    chk("rd_hit_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("rd_hit_q", bus_l1d_q, 32'hDEADBEEF);
    tick();
    chk("rd_hit_nstart", n_sdc_start - s0, 32'd0);

    // write-through to aliasing address replaces the line; q untouched
    issue("wr", 23'h000090, 32'h12345678, 1'b1);
    serve("wr", 23'h000090, 32'h12345678, 1'b1, 32'hFFFFFFFF, 3);
    chk("wr_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("wr_q_kept", bus_l1d_q, 32'hDEADBEEF);
    tick();
    s0 = n_sdc_start;
    issue("wr_alloc_hit", 23'h000090, 32'h0, 1'b0);
    tick();
    chk("wr_alloc_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("wr_alloc_q", bus_l1d_q, 32'h12345678);
    tick();
    chk("wr_alloc_nstart", n_sdc_start - s0, 32'd0);
    issue("rd_evicted", 23'h000010, 32'h0, 1'b0);
    serve("rd_evicted", 23'h000010, 32'h0, 1'b0, 32'hCAFEF00D, 2);
    chk("rd_evicted_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("rd_evicted_q", bus_l1d_q, 32'hCAFEF00D);
    tick();

    // start pulsed while busy in MEM_RD is ignored
    s0 = n_sdc_start; d0 = n_done;
    issue("busy", 23'h000025, 32'h0, 1'b0);
    tick();
    chk("busy_sdc_start", {31'b0, sdc_start}, 32'd1);
    chk("busy_ready_low", {31'b0, bus_l1d_ready}, 32'd0);
    bus_l1d_start = 1'b1;
    bus_l1d_addr  = 23'h000010;
    tick();
    bus_l1d_start = 1'b0;
    chk("busy_addr_kept", {9'b0, sdc_addr}, 32'h25);
    tick();
    sdc_q = 32'h55AA55AA; sdc_done = 1'b1;
    tick();
    sdc_done = 1'b0;
    chk("busy_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("busy_ready_in_done", {31'b0, bus_l1d_ready}, 32'd0);
    chk("busy_q", bus_l1d_q, 32'h55AA55AA);
    tick();
    chk("busy_ready_after", {31'b0, bus_l1d_ready}, 32'd1);
    tick();
    tick();
    chk("busy_ndone", n_done - d0, 32'd1);
    chk("busy_nstart", n_sdc_start - s0, 32'd1);

    // reset in MEM_RD abandons the miss; late sdc_done ignored
    d0 = n_done;
    issue("rst_mid", 23'h000090, 32'h0, 1'b0);
    tick();
    chk("rst_mid_in_mem_rd", {31'b0, sdc_start}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_sdc_start", {31'b0, sdc_start}, 32'd0);
    chk("rst_mid_ready", {31'b0, bus_l1d_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_q", bus_l1d_q, 32'h0);
    chk("rst_mid_ready_after", {31'b0, bus_l1d_ready}, 32'd1);
    tick();
    sdc_q = 32'h77777777; sdc_done = 1'b1;
    tick();
    sdc_done = 1'b0;
    chk("late_done_ignored", {31'b0, bus_l1d_done}, 32'd0);
    tick();
    chk("late_ndone", n_done - d0, 32'd0);
    chk("late_q", bus_l1d_q, 32'h0);
    s0 = n_sdc_start;
    issue("rd_after_rst", 23'h000010, 32'h0, 1'b0);
    serve("rd_after_rst", 23'h000010, 32'h0, 1'b0, 32'h0BADF00D, 1);
    chk("rd_after_rst_done", {31'b0, bus_l1d_done}, 32'd1);
    chk("rd_after_rst_q", bus_l1d_q, 32'h0BADF00D);
    tick();
    chk("rd_after_rst_nstart", n_sdc_start - s0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l1d_cache.md
L1D_CACHE -- requirements
Module: l1d_cache

Interface
- REQ-001 SHALL have parameter LINES, default 128, number of direct-mapped one-word lines (power of two).
- REQ-002 SHALL have parameter ADDR_W, default 23, CPU-side word address width.
- REQ-003 SHALL have port clk100  in  1  system clock, all logic on rising edge.
- REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
- REQ-005 SHALL have port bus_l1d_addr  in  23  CPU word address.
- REQ-006 SHALL have port bus_l1d_start  in  1  request strobe, sampled only while ready=1.
- REQ-007 SHALL have port bus_l1d_data  in  32  CPU write data.
- REQ-008 SHALL have port bus_l1d_we  in  1  1=write, 0=read.
- REQ-009 SHALL have port bus_l1d_q  out  32  read result.
- REQ-010 SHALL have port bus_l1d_done  out  1  one-cycle completion pulse.
- REQ-011 SHALL have port bus_l1d_ready  out  1  idle, new request acceptable.
- REQ-012 SHALL have ports sdc_addr out 23, sdc_data out 32, sdc_we out 1, sdc_start out 1, sdc_q in 32, sdc_done in 1: SDRAM controller word port.

Function
- REQ-013 SHALL split address as index=addr[log2(LINES)-1:0], tag=remaining upper bits (16 bits at default).
- REQ-014 SHALL implement states IDLE, LOOKUP, MEM_RD, MEM_WR, DONE.
- REQ-015 IDLE: ready=1; start=1 latches addr/data/we, next state LOOKUP; start while ready=0 SHALL be ignored.
- REQ-016 LOOKUP: read hit (valid and tag match) -> DONE with q=line data; read miss -> MEM_RD; any write -> MEM_WR.
- REQ-017 On entry to MEM_RD/MEM_WR, sdc_start SHALL pulse exactly one cycle; sdc_addr/sdc_data/sdc_we SHALL be held stable until sdc_done.
- REQ-018 MEM_RD: on sdc_done, line[index] <= {valid=1, tag, sdc_q}, q <= sdc_q, next DONE.
- REQ-019 MEM_WR (write-through, write-allocate): on sdc_done, line[index] <= {valid=1, tag, data}, next DONE.
- REQ-020 DONE: done=1 for exactly one cycle, next IDLE; q SHALL remain stable until the next completed read.
- REQ-021 Latency: read hit done 2 cycles after accepted start; miss/write done 1 cycle after sdc_done.
- REQ-022 sdc_done outside MEM_RD/MEM_WR SHALL be ignored.
- REQ-023 Write to a line holding a different tag SHALL replace it (no dirty state exists).
- REQ-024 Index wrap: addresses differing only in tag SHALL alias the same line and evict each other.

Reset
- REQ-025 Reset SHALL force state IDLE, all valid bits 0, q=0, done=0, sdc_start=0, sdc_we=0, ready=0 during reset cycle.
- REQ-026 Reset mid-transaction SHALL abandon it with no done pulse and no line update; a late sdc_done SHALL be ignored.
- REQ-027 Tag/data arrays SHALL need no reset; only valid bits are cleared.

Structure
- REQ-028 Shared package l1d_pkg SHALL hold the state enum, LINES, ADDR_W, and derived INDEX_W/TAG_W constants.
- REQ-029 Tag/valid/data storage SHALL be one sub-module l1d_tag_store (one read port, one write port, valid clear on reset).

Verification
- REQ-030 After reset, read 0x000010, sdc_q=0xDEADBEEF after 5 cycles -> one sdc_start, q=0xDEADBEEF, single done.
- REQ-031 Repeat read 0x000010 -> no sdc_start, done 2 cycles after start, q=0xDEADBEEF.
- REQ-032 Write 0x000090 data 0x12345678 (same index, new tag) -> sdc write 0x12345678, then read 0x000010 misses to SDRAM.
- REQ-033 Start pulsed during MEM_RD -> ignored, exactly one done, ready low until DONE passes.
- REQ-034 Reset asserted in MEM_RD, sdc_done 2 cycles later -> no done, read 0x000010 then misses (valid cleared).
